// File: rtl/cxapbasyncbridge_cdc_corrupt_mc.sv
// Multi-channel CDC corruption injector: after a data change on a channel,
// q is inverted, held stale or randomised for a window of DEPTH extra cycles.
module cxapbasyncbridge_cdc_corrupt_mc #(
  parameter int          WIDTH = 8,
  parameter int          NCHAN = 4,
  parameter int          DEPTH = 2,
  parameter logic [31:0] SEED  = 32'hACE1_2468
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [NCHAN-1:0]       sync,
  input  logic [NCHAN*WIDTH-1:0] d,
  output logic [NCHAN*WIDTH-1:0] q,
  output logic [NCHAN-1:0]       active,
  output logic [15:0]            evt_count
);

  localparam logic [7:0]  DEPTH8 = 8'(DEPTH);
  localparam logic [31:0] TAPS   = 32'h8020_0003;

  logic [NCHAN-1:0][WIDTH-1:0] d_prev_q;
  logic [NCHAN-1:0][WIDTH-1:0] held_q, held_d;
  logic [NCHAN-1:0][7:0]       cnt_q, cnt_d;
  logic                        primed_q;
  logic [31:0]                 lfsr_q, lfsr_d;
  logic [15:0]                 evt_q, evt_d;
  logic [NCHAN-1:0]            trig;
  logic                        corrupt_en;

  assign corrupt_en = enable & (mode != 2'd0);

  always_comb begin
    logic [WIDTH-1:0] dc;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rnd;
    trig   = '0;
    active = '0;
    q      = d;
    cnt_d  = cnt_q;
    held_d = held_q;
    dc     = '0;
    pc     = '0;
    rnd    = '0;
    for (int c = 0; c < NCHAN; c++) begin
      dc  = d[c*WIDTH +: WIDTH];
      pc  = d_prev_q[c];
      rnd = WIDTH'((lfsr_q << c) | (lfsr_q >> (32 - c)));
      trig[c] = (dc != pc) & primed_q & ~reset
              & corrupt_en & ~sync[c];
      active[c] = trig[c] | (cnt_q[c] != 8'd0);
      if (trig[c])
        cnt_d[c] = DEPTH8;
      else if (cnt_q[c] != 8'd0)
        cnt_d[c] = cnt_q[c] - 8'd1;
      // only a window-opening trigger snapshots the stale value
      if (trig[c] && cnt_q[c] == 8'd0)
        held_d[c] = pc;
      if (active[c] & corrupt_en & ~sync[c]) begin
        case (mode)
          2'd1:    q[c*WIDTH +: WIDTH] = ~dc;
          2'd2:    q[c*WIDTH +: WIDTH] =
                     (cnt_q[c] == 8'd0) ? pc : held_q[c];
          default: q[c*WIDTH +: WIDTH] = rnd;
        endcase
      end
    end
  end

  assign lfsr_d = {1'b0, lfsr_q[31:1]}
                ^ (lfsr_q[0] ? TAPS : 32'd0);

  assign evt_d = (|trig && evt_q != 16'hFFFF)
               ? evt_q + 16'd1 : evt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_prev_q <= '0;
      held_q   <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      lfsr_q   <= SEED;
      evt_q    <= '0;
    end else begin
      d_prev_q <= d;
      held_q   <= held_d;
      cnt_q    <= cnt_d;
      primed_q <= 1'b1;
      lfsr_q   <= lfsr_d;
      evt_q    <= evt_d;
    end
  end

  assign evt_count = evt_q;

endmodule

// File: tb/tb_cxapbasyncbridge_cdc_corrupt_mc.sv
// Bench: two instances (DEPTH 2 and 0) on shared stimulus, checked
// against a cycle-level reference model of the corruption rules.
module tb_cxapbasyncbridge_cdc_corrupt_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  mode = 2'd1;
  logic [3:0]  sync = '0;
  logic [31:0] d = '0;
  logic [31:0] qa, qb;
  logic [3:0]  aa, ab;
  logic [15:0] ea, eb;

  int n_tot = 0;
  int n_bad = 0;
  bit do_chk = 1'b0;

  always #5 clk = ~clk;

  cxapbasyncbridge_cdc_corrupt_mc #(
    .WIDTH(8), .NCHAN(4), .DEPTH(2)
  ) u_a (
    .clk(clk), .reset(reset), .enable(enable),
    .mode(mode), .sync(sync), .d(d),
    .q(qa), .active(aa), .evt_count(ea)
  );

  cxapbasyncbridge_cdc_corrupt_mc #(
    .WIDTH(8), .NCHAN(4), .DEPTH(0)
  ) u_b (
    .clk(clk), .reset(reset), .enable(enable),
    .mode(mode), .sync(sync), .d(d),
    .q(qb), .active(ab), .evt_count(eb)
  );

  // reference model state
  int        dep [2] = '{2, 0};
  bit [7:0]  m_prev [4];
  bit        m_primed;
  int        m_cnt [2][4];
  bit [7:0]  m_held [2][4];
  bit [31:0] m_lfsr;
  int        m_evt;
  bit [3:0]  m_tr;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] rotl(bit [31:0] v, int n);
    bit [31:0] r = v;
    repeat (n) r = {r[30:0], r[31]};
    return r;
  endfunction

  function automatic bit [31:0] lfsr_step(bit [31:0] v);
    bit        b = v[0];
    bit [31:0] r = v >> 1;
    if (b) r ^= (32'd1 << 31) | (32'd1 << 21) | 32'd3;
    return r;
  endfunction

  task automatic m_reset();
    m_primed = 1'b0;
    m_lfsr   = 32'hACE1_2468;
    m_evt    = 0;
    for (int c = 0; c < 4; c++) begin
      m_prev[c] = '0;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k][c]  = 0;
        m_held[k][c] = '0;
      end
    end
  endtask

  // settle to the negedge and compare outputs against the model
  task automatic sample();
    bit [7:0]  dc, eq, got;
    bit [31:0] r;
    bit        act, gact;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      dc = d[c*8 +: 8];
      m_tr[c] = !reset && m_primed && enable && !sync[c]
             && mode != 2'd0 && dc != m_prev[c];
    end
    if (do_chk) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++) begin
          dc  = d[c*8 +: 8];
          act = m_tr[c] || m_cnt[k][c] > 0;
          eq  = dc;
          if (act && enable && !sync[c] && mode != 2'd0) begin
            r = rotl(m_lfsr, c);
            if (mode == 2'd1) eq = ~dc;
            else if (mode == 2'd2)
              eq = (m_cnt[k][c] == 0) ? m_prev[c] : m_held[k][c];
            else eq = r[7:0];
          end
          got  = k ? qb[c*8 +: 8] : qa[c*8 +: 8];
          gact = k ? ab[c] : aa[c];
          chk($sformatf("q%0d_ch%0d", k, c), 32'(got), 32'(eq));
          chk($sformatf("act%0d_ch%0d", k, c),
              32'(gact), 32'(act));
        end
      end
      chk("evt_a", 32'(ea), 32'(m_evt));
      chk("evt_b", 32'(eb), 32'(m_evt));
    end
  endtask

  // clock edge: advance the model, then step past the edge
  task automatic adv();
    @(posedge clk);
    if (reset) m_reset();
    else begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 4; c++) begin
          if (m_tr[c]) begin
            if (m_cnt[k][c] == 0) m_held[k][c] = m_prev[c];
            m_cnt[k][c] = dep[k];
          end else if (m_cnt[k][c] > 0) m_cnt[k][c]--;
        end
      for (int c = 0; c < 4; c++) m_prev[c] = d[c*8 +: 8];
      m_primed = 1'b1;
      m_lfsr = lfsr_step(m_lfsr);
      if (m_tr != 0 && m_evt < 65535) m_evt++;
    end
    #1;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  initial begin
    bit [31:0] r;
    int        e0;
    m_reset();
    @(posedge clk);
    #1;
    do_chk = 1'b1;
    // reset state, then non-zero d held across release
    tick();
    d = 32'h1122_3344;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("evt_after_release", 32'(ea), 32'd0);

    // INVERT window on ch0
    enable = 1'b0;
    d = '0;
    tick();
    enable = 1'b1;
    tick();
    d[7:0] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("inv_q0", 32'(qa[7:0]), 32'h A5);
      chk("inv_act0", 32'(aa[0]), 32'd1);
      adv();
    end
    sample();
    chk("inv_q0_end", 32'(qa[7:0]), 32'h5A);
    chk("inv_act0_end", 32'(aa[0]), 32'd0);
    chk("inv_evt", 32'(ea), 32'd1);
    adv();

    // STALE window with a retrigger on ch1
    mode = 2'd2;
    enable = 1'b0;
    d[15:8] = 8'h11;
    tick();
    tick();
    enable = 1'b1;
    tick();
    d[15:8] = 8'h22;
    sample();
    chk("stale_t0", 32'(qa[15:8]), 32'h11);
    adv();
    d[15:8] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("stale_tn", 32'(qa[15:8]), 32'h11);
      adv();
    end
    sample();
    chk("stale_end", 32'(qa[15:8]), 32'h33);
    chk("stale_evt", 32'(ea), 32'd3);
    adv();

    // RANDOM with DEPTH=0 on ch2
    mode = 2'd3;
    d[23:16] = d[23:16] ^ 8'h3C;
    sample();
    r = rotl(m_lfsr, 2);
    chk("rand_q2", 32'(qb[23:16]), 32'(r[7:0]));
    chk("rand_act2", 32'(ab[2]), 32'd1);
    adv();
    sample();
    chk("rand_act2_end", 32'(ab[2]), 32'd0);
    adv();

    // bypass via sync and via enable on ch3
    mode = 2'd1;
    sync = 4'b1000;
    e0 = m_evt;
    for (int i = 0; i < 6; i++) begin
      d[31:24] = ~d[31:24];
      tick();
    end
    sync = '0;
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d[31:24] = ~d[31:24];
      tick();
    end
    chk("bypass_evt", 32'(ea), 32'(e0));
    enable = 1'b1;

    // reset pulsed mid-window
    d[7:0] = d[7:0] + 8'd1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    chk("rst_mid_q", qa, d);
    chk("rst_mid_act", 32'(aa), 32'd0);
    adv();
    tick();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(2) == 0) d[c*8 +: 8] = 8'($urandom);
      if ($urandom_range(7) == 0) mode = 2'($urandom);
      enable = ($urandom_range(9) != 0);
      for (int c = 0; c < 4; c++)
        sync[c] = ($urandom_range(7) == 0);
      reset = ($urandom_range(59) == 0);
      tick();
    end

    // saturation of evt_count
    reset = 1'b0;
    enable = 1'b1;
    mode = 2'd1;
    sync = '0;
    do_chk = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      d[0] = ~d[0];
      tick();
    end
    do_chk = 1'b1;
    sample();
    chk("sat_a", 32'(ea), 32'h0000_FFFF);
    chk("sat_b", 32'(eb), 32'h0000_FFFF);
    adv();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
